// File: rtl/sqr_burst_gen.sv
// sqr_burst_gen: square-wave generator with separate high/low segment lengths
// (programmable duty cycle). Runs in burst mode (N periods, then stop) or
// continuous mode. Configuration changes take effect at period boundaries.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_load            pulse: capture high_len/low_len/amplitude/sel_phase/burst_num
//   high_len, low_len   segment lengths in cycles (0 is treated as 1)
//   amplitude           peak level A; the complementary level is ~A
//   sel_phase           0: first segment is A, 1: first segment is ~A
//   burst_num           periods per burst, 0 = continuous
//   start, stop         run control pulses
//   wave_out            registered output sample
//   busy                high while the generator is running
//   period_tick         pulse on the last sample of each period
//   done                pulse for the cycle in which a run completes
//
// Optional feature: define SQR_DEADTIME_EN to insert DEAD_LEN mid-scale
// samples between segments. The dead gap before a run ends is skipped.
module sqr_burst_gen #(
  parameter int unsigned DT_W     = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned BURST_W  = 8,
  parameter int unsigned DEAD_LEN = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [CNT_W-1:0]   high_len,
  input  logic [CNT_W-1:0]   low_len,
  input  logic [DT_W-1:0]    amplitude,
  input  logic               sel_phase,
  input  logic [BURST_W-1:0] burst_num,
  input  logic               start,
  input  logic               stop,
  output logic [DT_W-1:0]    wave_out,
  output logic               busy,
  output logic               period_tick,
  output logic               done
);

  typedef struct packed {
    logic [CNT_W-1:0]   high;
    logic [CNT_W-1:0]   low;
    logic [DT_W-1:0]    amp;
    logic               phase;
    logic [BURST_W-1:0] burst;
  } cfg_t;

  localparam cfg_t CFG_RST = '{high: CNT_W'(1), low: CNT_W'(1), amp: '0, phase: 1'b0, burst: '0};

`ifdef SQR_DEADTIME_EN
  localparam logic [DT_W-1:0]  MID_LVL   = {1'b1, {(DT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_LEN > 1) ? DEAD_LEN - 1 : 0);
  typedef enum logic [2:0] {S_IDLE, S_HIGH, S_LOW, S_DEAD, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;
`endif

  // Index of the last cycle of a segment; a zero length behaves as one cycle.
  function automatic logic [CNT_W-1:0] last_idx(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  // Segment level: first segment is A unless phase-inverted.
  function automatic logic [DT_W-1:0] seg_lvl(input cfg_t c, input logic second);
    return (c.phase ^ second) ? ~c.amp : c.amp;
  endfunction

  state_t             state, state_d;
  cfg_t               act_cfg, pnd_cfg, in_cfg, eff_cfg;
  logic               pnd_vld;
  logic               idle_en, idle_en_d;
  logic               stop_pend, stop_d;
  logic [CNT_W-1:0]   seg_cnt, seg_d;
  logic [BURST_W-1:0] per_cnt, per_d;
  logic [BURST_W:0]   per_inc;
  logic               running, cfg_direct, wrap, burst_hit;
  logic [DT_W-1:0]    wave_d;
  logic               busy_d, tick_d, done_d;
`ifdef SQR_DEADTIME_EN
  logic               dead_low, dead_low_d;
`endif

  assign in_cfg = {high_len, low_len, amplitude, sel_phase, burst_num};

`ifdef SQR_DEADTIME_EN
  assign running = (state == S_HIGH) || (state == S_LOW) || (state == S_DEAD);
`else
  assign running = (state == S_HIGH) || (state == S_LOW);
`endif

  // While idle a load goes straight to the active set; while running it waits.
  assign cfg_direct = cfg_load && !running;
  assign wrap       = (state == S_LOW) && (seg_cnt == last_idx(act_cfg.low));
  assign per_inc    = (BURST_W+1)'(per_cnt) + (BURST_W+1)'(1);
  assign burst_hit  = (act_cfg.burst != '0) && (per_inc >= (BURST_W+1)'(act_cfg.burst));

  // Config that will be active after this edge; drives the next sample.
  always_comb begin
    if (wrap && pnd_vld)  eff_cfg = pnd_cfg;
    else if (cfg_direct)  eff_cfg = in_cfg;
    else                  eff_cfg = act_cfg;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    seg_d     = seg_cnt + CNT_W'(1);
    per_d     = per_cnt;
    stop_d    = stop_pend;
    idle_en_d = idle_en | cfg_direct;
`ifdef SQR_DEADTIME_EN
    dead_low_d = dead_low;
`endif
    wave_d = '0;
    busy_d = 1'b0;
    tick_d = 1'b0;
    done_d = 1'b0;

    case (state)
      S_IDLE: begin
        seg_d  = '0;
        stop_d = 1'b0;
        if (start) begin
          state_d   = S_HIGH;
          per_d     = '0;
          idle_en_d = 1'b1;
        end
      end
      S_HIGH: begin
        stop_d = stop_pend | stop;
        if (seg_cnt == last_idx(act_cfg.high)) begin
          seg_d = '0;
`ifdef SQR_DEADTIME_EN
          state_d    = S_DEAD;
          dead_low_d = 1'b1;
`else
          state_d = S_LOW;
`endif
        end
      end
      S_LOW: begin
        stop_d = stop_pend | stop;
        if (wrap) begin
          seg_d = '0;
          per_d = per_inc[BURST_W-1:0];
          if (burst_hit || stop_pend || stop) begin
            state_d = S_DONE;
            stop_d  = 1'b0;
          end else begin
`ifdef SQR_DEADTIME_EN
            state_d    = S_DEAD;
            dead_low_d = 1'b0;
`else
            state_d = S_HIGH;
`endif
          end
        end
      end
`ifdef SQR_DEADTIME_EN
      S_DEAD: begin
        stop_d = stop_pend | stop;
        if (seg_cnt == DEAD_LAST) begin
          seg_d   = '0;
          state_d = dead_low ? S_LOW : S_HIGH;
        end
      end
`endif
      S_DONE: begin
        seg_d   = '0;
        stop_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        seg_d   = '0;
        stop_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs follow the state being entered so they line up with it.
    case (state_d)
      S_HIGH:  wave_d = seg_lvl(eff_cfg, 1'b0);
      S_LOW:   wave_d = seg_lvl(eff_cfg, 1'b1);
`ifdef SQR_DEADTIME_EN
      S_DEAD:  wave_d = MID_LVL;
`endif
      default: wave_d = idle_en_d ? seg_lvl(eff_cfg, 1'b1) : '0;
    endcase
`ifdef SQR_DEADTIME_EN
    busy_d = (state_d == S_HIGH) || (state_d == S_LOW) || (state_d == S_DEAD);
`else
    busy_d = (state_d == S_HIGH) || (state_d == S_LOW);
`endif
    tick_d = (state_d == S_LOW) && (seg_d == last_idx(eff_cfg.low));
    done_d = (state_d == S_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      seg_cnt     <= '0;
      per_cnt     <= '0;
      stop_pend   <= 1'b0;
      idle_en     <= 1'b0;
      wave_out    <= '0;
      busy        <= 1'b0;
      period_tick <= 1'b0;
      done        <= 1'b0;
`ifdef SQR_DEADTIME_EN
      dead_low    <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      seg_cnt     <= seg_d;
      per_cnt     <= per_d;
      stop_pend   <= stop_d;
      idle_en     <= idle_en_d;
      wave_out    <= wave_d;
      busy        <= busy_d;
      period_tick <= tick_d;
      done        <= done_d;
`ifdef SQR_DEADTIME_EN
      dead_low    <= dead_low_d;
`endif
    end
  end

  // Active/pending config; a pending set is promoted on the last LOW cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_cfg <= CFG_RST;
      pnd_cfg <= CFG_RST;
      pnd_vld <= 1'b0;
    end else begin
      if (wrap && pnd_vld) begin
        act_cfg <= pnd_cfg;
        pnd_vld <= 1'b0;
      end
      if (cfg_load) begin
        if (cfg_direct) begin
          act_cfg <= in_cfg;
        end else begin
          pnd_cfg <= in_cfg;
          pnd_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sqr_burst_gen.sv
// Bench for sqr_burst_gen: a period-level reference model plans the samples
// of each period into a queue; expected outputs per cycle go to a scoreboard
// queue that a negedge monitor pops and compares.
module tb_sqr_burst_gen;

  localparam int unsigned DT_W     = 8;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned BURST_W  = 8;
  localparam int unsigned DEAD_LEN = 2;
  localparam int          MAXV     = 255;
  localparam int          MIDV     = 128;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_load = 1'b0;
  logic [CNT_W-1:0]   high_len = '0;
  logic [CNT_W-1:0]   low_len = '0;
  logic [DT_W-1:0]    amplitude = '0;
  logic               sel_phase = 1'b0;
  logic [BURST_W-1:0] burst_num = '0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [DT_W-1:0]    wave_out;
  logic               busy;
  logic               period_tick;
  logic               done;

  sqr_burst_gen #(
    .DT_W(DT_W), .CNT_W(CNT_W), .BURST_W(BURST_W), .DEAD_LEN(DEAD_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load),
    .high_len(high_len), .low_len(low_len), .amplitude(amplitude),
    .sel_phase(sel_phase), .burst_num(burst_num),
    .start(start), .stop(stop),
    .wave_out(wave_out), .busy(busy), .period_tick(period_tick), .done(done)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int wave; bit busy; bit tick; bit done; } exp_t;
  typedef struct { int wave; bit tick; } smp_t;

  exp_t exp_q[$];
  smp_t plan[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state
  int m_mode;   // 0 idle, 1 running, 2 done cycle
  int a_high, a_low, a_amp, a_ph, a_burst;
  int p_high, p_low, p_amp, p_ph, p_burst;
  bit p_v, idle_en, stop_req;
  int periods;

  function automatic int lvl1(int amp, int ph);
    return ph ? MAXV - amp : amp;
  endfunction
  function automatic int lvl2(int amp, int ph);
    return ph ? amp : MAXV - amp;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    a_high = 1; a_low = 1; a_amp = 0; a_ph = 0; a_burst = 0;
    p_high = 1; p_low = 1; p_amp = 0; p_ph = 0; p_burst = 0;
    p_v = 0; idle_en = 0; stop_req = 0; periods = 0;
    plan.delete();
  endtask

  // Lay out every sample of one period using the active config.
  task automatic build_period(input bit lead_dead);
    smp_t s;
    int h, l;
    h = (a_high == 0) ? 1 : a_high;
    l = (a_low == 0) ? 1 : a_low;
`ifdef SQR_DEADTIME_EN
    if (lead_dead) for (int i = 0; i < DEAD_LEN; i++) begin s.wave = MIDV; s.tick = 0; plan.push_back(s); end
`else
    if (lead_dead) h = h + 0;
`endif
    for (int i = 0; i < h; i++) begin s.wave = lvl1(a_amp, a_ph); s.tick = 0; plan.push_back(s); end
`ifdef SQR_DEADTIME_EN
    for (int i = 0; i < DEAD_LEN; i++) begin s.wave = MIDV; s.tick = 0; plan.push_back(s); end
`endif
    for (int i = 0; i < l; i++) begin s.wave = lvl2(a_amp, a_ph); s.tick = (i == l - 1); plan.push_back(s); end
  endtask

  task automatic take_inputs_active();
    a_high = int'(high_len); a_low = int'(low_len); a_amp = int'(amplitude);
    a_ph = int'(sel_phase); a_burst = int'(burst_num);
  endtask

  task automatic take_inputs_pending();
    p_high = int'(high_len); p_low = int'(low_len); p_amp = int'(amplitude);
    p_ph = int'(sel_phase); p_burst = int'(burst_num);
    p_v = 1;
  endtask

  task automatic pop_plan(output exp_t e);
    smp_t s;
    s = plan.pop_front();
    e.wave = s.wave; e.busy = 1; e.tick = s.tick; e.done = 0;
  endtask

  // Advance the model by one clock edge; push the expected next-cycle outputs.
  task automatic model_step();
    exp_t e;
    e.wave = 0; e.busy = 0; e.tick = 0; e.done = 0;
    if (!rst_n) begin
      model_reset();
    end else if (m_mode != 1) begin
      bit was_idle;
      was_idle = (m_mode == 0);
      stop_req = 0;
      if (cfg_load) begin take_inputs_active(); idle_en = 1; end
      if (was_idle && start) begin
        idle_en = 1; periods = 0; plan.delete();
        build_period(0);
        m_mode = 1;
        pop_plan(e);
      end else begin
        m_mode = 0;
        e.wave = idle_en ? lvl2(a_amp, a_ph) : 0;
      end
    end else begin
      if (stop) stop_req = 1;
      if (plan.size() == 0) begin
        int inc;
        bit hit;
        inc = periods + 1;
        hit = (a_burst != 0) && (inc >= a_burst);
        periods = inc % 256;
        if (p_v) begin
          a_high = p_high; a_low = p_low; a_amp = p_amp; a_ph = p_ph; a_burst = p_burst;
          p_v = 0;
        end
        if (cfg_load) take_inputs_pending();
        if (hit || stop_req) begin
          m_mode = 2; stop_req = 0;
          e.wave = lvl2(a_amp, a_ph); e.done = 1;
        end else begin
          build_period(1);
          pop_plan(e);
        end
      end else begin
        if (cfg_load) take_inputs_pending();
        pop_plan(e);
      end
    end
    exp_q.push_back(e);
  endtask

  // One clock with the given control pulses held across the edge.
  task automatic step_in(input bit s, input bit sp, input bit ld);
    start = s; stop = sp; cfg_load = ld;
    @(posedge clk);
    model_step();
    #1;
    start = 0; stop = 0; cfg_load = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step_in(0, 0, 0);
  endtask

  task automatic set_cfg(input int h, input int l, input int a, input int ph, input int b);
    high_len = CNT_W'(h); low_len = CNT_W'(l); amplitude = DT_W'(a);
    sel_phase = 1'(ph); burst_num = BURST_W'(b);
  endtask

  // Asynchronous reset asserted between edges, held for n edges.
  task automatic reset_mid(input int n);
    exp_t e;
    @(posedge clk);
    model_step();
    model_reset();
    void'(exp_q.pop_back());
    e.wave = 0; e.busy = 0; e.tick = 0; e.done = 0;
    exp_q.push_back(e);
    #2 rst_n = 0;
    for (int i = 0; i < n; i++) begin @(posedge clk); model_step(); end
    #1 rst_n = 1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  // Monitor: every negedge, pop one expected sample and compare.
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("wave_out", int'(wave_out), e.wave);
      chk("busy", int'(busy), int'(e.busy));
      chk("period_tick", int'(period_tick), int'(e.tick));
      chk("done", int'(done), int'(e.done));
    end
  end

  initial begin
    model_reset();
    idle_cycles(3);
    rst_n = 1;
    idle_cycles(2);

    // Burst of two periods, then the opposite phase
    set_cfg(3, 5, 200, 0, 2); step_in(0, 0, 1); idle_cycles(2);
    step_in(1, 0, 0); idle_cycles(22);
    set_cfg(3, 5, 200, 1, 2); step_in(0, 0, 1);
    step_in(1, 0, 0); idle_cycles(22);

    // Stop in IDLE has no effect; start+stop together starts
    step_in(0, 1, 0); idle_cycles(2);
    set_cfg(2, 2, 90, 0, 0); step_in(0, 0, 1);
    step_in(1, 1, 0); idle_cycles(13);
    step_in(0, 1, 0); idle_cycles(8);

    // Live reconfiguration while running
    set_cfg(4, 4, 17, 0, 0); step_in(0, 0, 1);
    step_in(1, 0, 0); idle_cycles(2);
    set_cfg(1, 7, 17, 0, 0); step_in(0, 0, 1);
    idle_cycles(20);
    step_in(0, 1, 0); idle_cycles(12);

    // Zero lengths, then reset in the middle of LOW
    set_cfg(0, 0, 240, 0, 0); step_in(0, 0, 1);
    step_in(1, 0, 0); idle_cycles(6);
    reset_mid(2);
    idle_cycles(4);

    // Randomised traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) set_cfg($urandom_range(0, 12), $urandom_range(0, 12),
                                             $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 3));
      else set_cfg($urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 3));
      if ($urandom_range(0, 699) == 0) reset_mid($urandom_range(1, 3));
      else step_in($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0);
    end

    idle_cycles(3);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sqr_burst_gen.md
Name: sqr_burst_gen

Overview:
- Parametrised successor of the fixed 50 % square-wave generator in the AI-match signal path.
- Generates a two-level square wave with independent high/low segment lengths, so duty cycle is programmable.
- Supports burst mode (N periods, then stop) or continuous mode, with start/stop control and glitch-free reconfiguration at period boundaries.
- Feeds the DAC-side sample path of the oscilloscope test design.

Parameters:
- DT_W, 8: output sample and amplitude width.
- CNT_W, 16: segment length counter width.
- BURST_W, 8: burst period counter width.
- DEAD_LEN, 2: dead-time cycles per transition; used only with SQR_DEADTIME_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- cfg_load  in  1  pulse; captures high_len, low_len, amplitude, sel_phase, burst_num.
- high_len  in  CNT_W  first-segment length in cycles; 0 treated as 1.
- low_len  in  CNT_W  second-segment length in cycles; 0 treated as 1.
- amplitude  in  DT_W  peak level A; complementary level is (2^DT_W-1)-A.
- sel_phase  in  1  0: first segment = A; 1: first segment = complement (180°).
- burst_num  in  BURST_W  periods per burst; 0 = continuous.
- start  in  1  pulse; begins generation from IDLE.
- stop  in  1  pulse; requests graceful stop at end of current period.
- wave_out  out  DT_W  registered sample.
- busy  out  1  high in HIGH/LOW/DEAD states.
- period_tick  out  1  one-cycle pulse, aligned with the last sample of each period.
- done  out  1  one-cycle pulse when a burst or stop completes.

Behaviour:
- Reset values: wave_out=0, busy=0, period_tick=0, done=0, state=IDLE.
- Config registers reset to: high_len=1, low_len=1, amplitude=0, sel_phase=0, burst_num=0.
- Level definitions: L1 = first-segment level, L2 = second-segment level, per sel_phase.
- Config, IDLE: cfg_load writes active registers directly.
- Config, running: cfg_load writes a pending set and a pending flag. The pending set is copied to active on the cycle the period wraps (last LOW cycle). Later cfg_load overwrites pending (last wins).
- States: IDLE, HIGH, LOW, DONE.
- IDLE -> HIGH on start.
- HIGH -> LOW after high_len cycles.
- LOW -> HIGH after low_len cycles, unless burst is complete or stop is pending; then LOW -> DONE.
- DONE -> IDLE after 1 cycle.
- Timing: the edge sampling start also loads wave_out=L1. wave_out holds L1 for exactly high_len cycles, then L2 for exactly low_len cycles. No extra latency between segments.
- Segment counter: counts 0..len-1 and clears on every segment change.
- Period counter: increments on each completed period.
  - burst_num=N>0: after period N completes, go to DONE.
  - burst_num=0: counter does not terminate the run.
  - BURST_W wrap is ignored in continuous mode.
- Stop:
  - In HIGH/LOW, sets stop_pend; the current period finishes, then DONE.
  - Ignored in IDLE/DONE.
- Start is ignored when not IDLE.
- start and stop in the same IDLE cycle: start wins, stop ignored.
- done: pulses for the DONE cycle. busy=0 in DONE and IDLE.
- Idle level: in IDLE and DONE, wave_out = L2 of the active config. This also applies after reset once the first cfg_load occurs; before that, wave_out stays 0 until start.
- Reset mid-run: immediate return to reset values; pending config and stop_pend are cleared.

Optional Feature:
- Macro SQR_DEADTIME_EN.
- Defined: adds a DEAD state between HIGH->LOW and LOW->HIGH. It lasts DEAD_LEN cycles with wave_out = 2^(DT_W-1) (mid-scale).
  - The DEAD state before a stop/burst-end is skipped, so DONE follows LOW directly.
  - period_tick stays on the last LOW cycle.
- Undefined: no DEAD state; DEAD_LEN is unused.

Test Plan:
- Burst: cfg A=200, high=3, low=5, sel_phase=0, burst=2; start -> wave_out 200×3, 55×5, 200×3, 55×5; period_tick on cycles 8 and 16; done at cycle 17; then IDLE holding 55.
- Phase: same config with sel_phase=1 -> 55×3, 200×5 pattern; idle level 200.
- Continuous + stop: burst=0, high=2, low=2; stop during the 2nd cycle of period 4 -> period 4 completes, done, busy falls. Stop pulsed in IDLE -> no effect.
- Live reconfig: running high=4/low=4; cfg_load high=1/low=7 mid-HIGH -> current period stays 4/4, next period is 1/7.
- Zero lengths and reset: high=0, low=0 -> alternating 1/1 square. Assert rst_n low mid-LOW -> all outputs 0 asynchronously; no done pulse after release.
- With SQR_DEADTIME_EN, DEAD_LEN=2: A=200, 3/5 -> 200×3, 128×2, 55×5, 128×2, 200×3…
